// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default widths for the SCLK generator.
package spi_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_HOLD, ST_FIN} state_t;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 6;
endpackage

// File: rtl/spi_half_cnt.sv
// spi_half_cnt: half-period counter, clears on clr or on reaching max; tc flags the terminal count.
module spi_half_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] r_cnt;
  assign cnt = r_cnt;
  assign tc  = r_cnt == max;
  always_ff @(posedge clk)
    r_cnt <= (rst || clr || tc) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI SCLK burst generator with sample/shift strobes, all four CPOL/CPHA modes.
// SPI_SCLK_GEN_CS_EN adds chip-select SETUP/HOLD phases and the cs_n port.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef SPI_SCLK_GEN_CS_EN
  , parameter int CS_SETUP = 2
  , parameter int CS_HOLD  = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             load_stb,
  output logic             sample_stb,
  output logic             shift_stb
`ifdef SPI_SCLK_GEN_CS_EN
  , output logic           cs_n
`endif
);
  state_t           r_state, w_next;
  logic [DIV_W-1:0] r_div, w_hcnt;
  logic [CNT_W-1:0] r_nbits;
  logic [CNT_W:0]   r_ecnt;
  logic             r_cpol, r_cpha, w_tc, w_last, w_toggle, w_lead;
  spi_half_cnt #(.W(DIV_W)) u_half (
    .clk(clk), .rst(rst), .clr(r_state != ST_RUN), .max(r_div), .cnt(w_hcnt), .tc(w_tc)
  );
  assign busy     = r_state != ST_IDLE;
  assign done     = r_state == ST_FIN;
  assign w_last   = r_ecnt == {r_nbits, 1'b0};
  assign w_toggle = (r_state == ST_RUN) && w_tc && !w_last;
  assign w_lead   = ~r_ecnt[0];
`ifdef SPI_SCLK_GEN_CS_EN
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  logic [7:0] r_pcnt;
  logic       r_cs_n;
  assign cs_n = r_cs_n;
  always_ff @(posedge clk) begin
    r_pcnt <= (rst || r_state != w_next) ? 8'd0 : r_pcnt + 8'd1;
    r_cs_n <= rst || !(w_next inside {ST_SETUP, ST_RUN, ST_HOLD});
  end
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (start) begin
`ifdef SPI_SCLK_GEN_CS_EN
          w_next = (nbits == '0) ? ST_FIN : ST_SETUP;
`else
          w_next = (nbits == '0) ? ST_FIN : ST_RUN;
`endif
        end
`ifdef SPI_SCLK_GEN_CS_EN
      ST_SETUP: w_next = (r_pcnt == SETUP_LAST) ? ST_RUN : ST_SETUP;
      ST_RUN:   w_next = w_last ? ST_HOLD : ST_RUN;
      ST_HOLD:  w_next = (r_pcnt == HOLD_LAST) ? ST_FIN : ST_HOLD;
`else
      ST_RUN:   w_next = w_last ? ST_FIN : ST_RUN;
`endif
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_nbits    <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_ecnt     <= '0;
      sclk       <= 1'b0;
      load_stb   <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
    end else begin
      r_state    <= w_next;
      load_stb   <= (w_next == ST_RUN) && (r_state != ST_RUN);
      sample_stb <= w_toggle && (w_lead ^ r_cpha);
      shift_stb  <= w_toggle && !(w_lead ^ r_cpha);
      sclk       <= (r_state == ST_IDLE) ? cpol : sclk ^ w_toggle;
      r_ecnt     <= (r_state == ST_IDLE) ? '0 : r_ecnt + (CNT_W+1)'(w_toggle);
      if (r_state == ST_IDLE && start) begin
        r_div   <= div;
        r_nbits <= nbits;
        r_cpol  <= cpol;
        r_cpha  <= cpha;
      end
    end
  end
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: randomized bursts checked cycle-by-cycle against a timing model of the SCLK generator.
module tb_spi_sclk_gen;
`ifdef SPI_SCLK_GEN_CS_EN
  localparam int PRE = 2, POST = 2;
`else
  localparam int PRE = 0, POST = 0;
`endif
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] div = '0;
  logic [5:0] nbits = '0;
  logic       busy, done, sclk, load_stb, sample_stb, shift_stb;
  logic       cs_obs;
  int         checks = 0, passed = 0;
  always #5 clk = ~clk;
`ifdef SPI_SCLK_GEN_CS_EN
  logic cs_n;
  assign cs_obs = cs_n;
  spi_sclk_gen #(.DIV_W(8), .CNT_W(6), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk(clk), .rst(rst), .start(start), .div(div), .nbits(nbits), .cpol(cpol), .cpha(cpha),
    .busy(busy), .done(done), .sclk(sclk), .load_stb(load_stb), .sample_stb(sample_stb),
    .shift_stb(shift_stb), .cs_n(cs_n));
`else
  assign cs_obs = 1'b1;
  spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .div(div), .nbits(nbits), .cpol(cpol), .cpha(cpha),
    .busy(busy), .done(done), .sclk(sclk), .load_stb(load_stb), .sample_stb(sample_stb),
    .shift_stb(shift_stb));
`endif

  task automatic run_burst(input int d, input int n, input bit pol, input bit pha, input bit hold,
                           input string name);
    int e2 = 2 * n;
    int total = (n == 0) ? 1 : PRE + e2 * (d + 1) + 1 + POST + 1;
    int n_sam = 0, n_sh = 0, r, ec;
    bit edge_e, lead, cs_e;
    logic [6:0] got, exp;
    @(negedge clk);
    div = 8'(d); nbits = 6'(n); cpol = pol; cpha = pha; start = 1'b1;
    for (int k = 1; k <= total + 2; k++) begin
      @(negedge clk);
      if (!hold || k == total) start = 1'b0;
      r = k - 1 - PRE;
      ec = 0;
      edge_e = 1'b0;
      if (n != 0 && r > 0) begin
        ec = r / (d + 1);
        edge_e = (r % (d + 1) == 0) && ec <= e2 && k < total;
        if (ec > e2) ec = e2;
      end
      lead = (ec % 2) == 1;
`ifdef SPI_SCLK_GEN_CS_EN
      cs_e = !(n != 0 && k < total);
`else
      cs_e = 1'b1;
`endif
      exp = {k <= total, k == total, pol ^ ec[0], n != 0 && k == PRE + 1,
             edge_e && (lead != pha), edge_e && (lead == pha), cs_e};
      got = {busy, done, sclk, load_stb, sample_stb, shift_stb, cs_obs};
      n_sam += int'(sample_stb);
      n_sh  += int'(shift_stb);
      checks++;
      if (got !== exp)
        $display("FAIL %s cycle %0d {busy,done,sclk,load,sample,shift,cs_n}: got %b expected %b",
                 name, k, got, exp);
      else passed++;
    end
    checks++;
    if (n_sam !== n || n_sh !== n)
      $display("FAIL %s strobe counts: got sample=%0d shift=%0d expected %0d each", name, n_sam, n_sh, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpol = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sclk, load_stb, sample_stb, shift_stb, cs_obs} !== 7'b0000001)
      $display("FAIL reset outputs: got %b expected 0000001",
               {busy, done, sclk, load_stb, sample_stb, shift_stb, cs_obs});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sclk !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle sclk follows cpol: got sclk=%b busy=%b expected sclk=1 busy=0", sclk, busy);
    else passed++;
    cpol = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0_div3();
    run_burst(3, 8, 1'b0, 1'b0, 1'b0, "mode0_div3_n8");
  endtask

  task automatic test_mode3_div0();
    run_burst(0, 1, 1'b1, 1'b1, 1'b0, "mode3_div0_n1");
  endtask

  task automatic test_zero_bits();
    run_burst(2, 0, 1'b0, 1'b0, 1'b0, "nbits0");
  endtask

  task automatic test_max_div();
    run_burst(255, 1, 1'b0, 1'b1, 1'b0, "div255");
  endtask

  task automatic test_back_to_back();
    run_burst(1, 3, 1'b1, 1'b0, 1'b1, "start_held");
    run_burst(0, 2, 1'b0, 1'b1, 1'b0, "second_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_burst(int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "random");
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    @(negedge clk);
    div = 8'd2; nbits = 6'd5; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, sclk, done} !== 3'b000)
      $display("FAIL reset_mid {busy,sclk,done}: got %b expected 000", {busy, sclk, done});
    else passed++;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done |= done;
    end
    checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid aftermath: got done_seen=%b busy=%b expected 0 0", saw_done, busy);
    else passed++;
    run_burst(1, 2, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mode0_div3();
    test_mode3_div0();
    test_zero_bits();
    test_max_div();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_burst(1, 4, 1'b0, 1'b0, 1'b0, "cs_frame_div1_n4");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
